// File: rtl/expslot_multi.sv
// -----------------------------------------------------------------------------
// expslot_multi
//   MSX secondary-slot expander for up to four primary slot channels. Each
//   expanded channel owns a subslot register at REG_ADDR. The register splits
//   the 64 KiB space into four 16 KiB pages, and each page gets a 2-bit
//   subslot field. Reading REG_ADDR returns the inverted register value. The
//   read data is driven while busreq is held high for HOLD_CYCLES clocks.
//   Non-expanded channels pass their primary select straight to subslot 0.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   enable   in   bus-sample qualifier (HOLD countdown ignores it)
//   addr     in   [15:0] Z80 address
//   cdin     in   [7:0]  CPU write data
//   cdout    out  [7:0]  registered read-back data (~register)
//   busreq   out  high while read data is being driven
//   sltsl_n  in   [NUM_PRI-1:0] active-low primary slot selects
//   rd_n     in   active-low read strobe
//   wr_n     in   active-low write strobe
//   slotsel  out  [4*NUM_PRI-1:0] one-hot subslot selects, 4 bits per channel
//   slotreg  out  [8*NUM_PRI-1:0] subslot register contents (debug)
// -----------------------------------------------------------------------------
module expslot_multi #(
    parameter int unsigned NUM_PRI     = 1,
    parameter logic [3:0]  EXPANDED    = 4'b0001,
    parameter logic [15:0] REG_ADDR    = 16'hFFFF,
    parameter logic [7:0]  RESET_VAL   = 8'h55,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [15:0]            addr,
    input  logic [7:0]             cdin,
    output logic [7:0]             cdout,
    output logic                   busreq,
    input  logic [NUM_PRI-1:0]     sltsl_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    output logic [4*NUM_PRI-1:0]   slotsel,
    output logic [8*NUM_PRI-1:0]   slotreg
);

    if (NUM_PRI < 1 || NUM_PRI > 4) begin : g_bad_num_pri
        $error("expslot_multi: NUM_PRI must be in 1..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("expslot_multi: HOLD_CYCLES must be in 1..15");
    end

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [3:0]                 hold_cnt;
    logic [NUM_PRI-1:0][7:0]    regs;
    logic [NUM_PRI-1:0]         sel_oh;
    logic                       sel_valid;
    logic                       reg_hit;
    logic                       load_reg;
    logic                       load_rd;
    logic [7:0]                 rd_val;

    // Maps the 2-bit field of page p to a one-hot subslot vector.
    function automatic logic [3:0] page_onehot(input logic [7:0] r, input logic [1:0] p);
        logic [1:0] f;
        case (p)
            2'd0:    f = r[1:0];
            2'd1:    f = r[3:2];
            2'd2:    f = r[5:4];
            default: f = r[7:6];
        endcase
        return 4'b0001 << f;
    endfunction

    assign reg_hit = enable && (addr == REG_ADDR);

    // Lowest-index selected expanded channel wins. Non-expanded channels
    // do not take part in this priority.
    always_comb begin
        sel_oh    = '0;
        sel_valid = 1'b0;
        rd_val    = '0;
        for (int unsigned i = 0; i < NUM_PRI; i++) begin
            if (!sel_valid && EXPANDED[i] && !sltsl_n[i]) begin
                sel_valid = 1'b1;
                sel_oh[i] = 1'b1;
                rd_val    = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_reg = 1'b0;
        load_rd  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reg_hit && sel_valid) begin
                    if (!wr_n) begin
                        load_reg = 1'b1;
                        state_nx = ST_WAIT;
                    end else if (!rd_n) begin
                        load_rd  = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Countdown is clock-driven, not enable-driven.
                if (hold_cnt == 4'd1) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Both strobes must be released before the next access is
                // accepted, so a long strobe commits only once.
                if (enable && rd_n && wr_n) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            cdout    <= '0;
            for (int unsigned i = 0; i < NUM_PRI; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (load_rd) begin
                hold_cnt <= HOLD_INIT;
                cdout    <= ~rd_val;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            for (int unsigned i = 0; i < NUM_PRI; i++) begin
                if (load_reg && sel_oh[i]) begin
                    regs[i] <= cdin;
                end
            end
        end
    end

    assign busreq  = (state == ST_HOLD);
    assign slotreg = regs;

    always_comb begin
        slotsel = '0;
        for (int unsigned i = 0; i < NUM_PRI; i++) begin
            if (EXPANDED[i]) begin
                if (!sltsl_n[i] && addr != REG_ADDR) begin
                    slotsel[4*i +: 4] = page_onehot(regs[i], addr[15:14]);
                end
            end else begin
                slotsel[4*i] = ~sltsl_n[i];
            end
        end
    end

endmodule
